accumulator_drain: RTL and testbench

- Readout stage directly downstream of the accumulator register file.
- On a start command it sweeps a contiguous range of accumulator rows: drives the register-file read address and tracks the fixed read latency.
- Captures each returned row into a small FIFO and presents rows on a ready/valid stream to the activation/unified-buffer write path.
- Uses credit-based issue, so no row is lost under back-pressure.

---
 rtl/accumulator_drain_pkg.sv | 35 +++
 rtl/accumulator_drain_fifo.sv | 71 +++++++
 rtl/accumulator_drain.sv | 169 ++++++++++++++++
 tb/tb_accumulator_drain.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_drain_pkg.sv
// Shared types and constants for the accumulator readout path.
// READ_LATENCY is the register-file read latency and is shared with the register file.
package accumulator_drain_pkg;

  localparam int MATRIX_WIDTH   = 14;
  localparam int WORD_WIDTH     = 32;
  localparam int REGISTER_DEPTH = 512;
  localparam int ADDR_WIDTH     = $clog2(REGISTER_DEPTH);
  localparam int READ_LATENCY   = 7;
  localparam int FIFO_DEPTH     = 8;

  typedef logic [ADDR_WIDTH-1:0]        ACCUMULATOR_ADDRESS_TYPE;
  typedef logic [WORD_WIDTH-1:0]        WORD_TYPE;
  typedef WORD_TYPE [MATRIX_WIDTH-1:0]  ROW_TYPE;
  typedef logic [ADDR_WIDTH:0]          ROW_COUNT_TYPE;

  typedef struct packed {
    ACCUMULATOR_ADDRESS_TYPE row;
    ROW_TYPE                 data;
  } drain_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  // Row addresses wrap modulo REGISTER_DEPTH, which need not be a power of two.
  function automatic ACCUMULATOR_ADDRESS_TYPE next_address(input ACCUMULATOR_ADDRESS_TYPE a);
    if (a == ACCUMULATOR_ADDRESS_TYPE'(REGISTER_DEPTH - 1)) return '0;
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/accumulator_drain_fifo.sv
// drain_fifo: synchronous return buffer of row+address entries.
// Push and pop may occur together in any fill state, including full and empty.
module drain_fifo
  import accumulator_drain_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  drain_entry_t                 push_entry,
  input  logic                         pop,
  output drain_entry_t                 head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  drain_entry_t     mem_q [DEPTH];
  drain_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign count      = count_q;
  assign head_entry = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push at full needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/accumulator_drain.sv
// accumulator_drain: sweeps a range of accumulator rows, tracks the register-file
// read latency and streams the returned rows out through a credit-limited FIFO.
module accumulator_drain
  import accumulator_drain_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    start,
  input  ACCUMULATOR_ADDRESS_TYPE base_address,
  input  ROW_COUNT_TYPE           row_count,
  output logic                    busy,
  output logic                    done,
  output ACCUMULATOR_ADDRESS_TYPE rf_read_address,
  input  ROW_TYPE                 rf_read_port,
  output logic                    out_valid,
  input  logic                    out_ready,
  output ROW_TYPE                 out_data,
  output ACCUMULATOR_ADDRESS_TYPE out_row,
  output logic                    out_last,
  output drain_state_e            dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_depth_check
    $error("accumulator_drain: FIFO_DEPTH must be at least READ_LATENCY+1");
  end

  drain_state_e            state_q, state_d;
  ROW_COUNT_TYPE           count_q, count_d;
  ROW_COUNT_TYPE           issued_q, issued_d;
  ROW_COUNT_TYPE           popped_q, popped_d;
  ACCUMULATOR_ADDRESS_TYPE addr_q, addr_d;
  logic [CNT_W-1:0]        in_flight_q, in_flight_d;
  logic [READ_LATENCY-1:0] sr_valid_q, sr_valid_d;
  ACCUMULATOR_ADDRESS_TYPE sr_row_q [READ_LATENCY];
  ACCUMULATOR_ADDRESS_TYPE sr_row_d [READ_LATENCY];
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full, fifo_empty;
  drain_entry_t            head, push_entry;
  logic                    issue, push, pop, last_row;
  logic [CNT_W:0]          credit_used;

  // Stream handshake: a row transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid, out_data, out_row and out_last hold
  // steady until that transfer, and out_valid never waits on out_ready.
  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_row   = head.row;
  assign pop       = out_valid && out_ready;
  assign last_row  = (popped_q == count_q - 1'b1);
  assign out_last  = out_valid && last_row;

  // Conservative credit: a pop in the same cycle is not counted as free space.
  assign credit_used = {1'b0, in_flight_q} + {1'b0, fifo_count};
  assign issue = (state_q == ST_ISSUE) && enable && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

  assign push       = enable && sr_valid_q[READ_LATENCY-1];
  assign push_entry = '{row: sr_row_q[READ_LATENCY-1], data: rf_read_port};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    issued_d    = issued_q;
    popped_d    = pop ? popped_q + 1'b1 : popped_q;
    addr_d      = addr_q;
    in_flight_d = in_flight_q;
    sr_valid_d  = sr_valid_q;
    sr_row_d    = sr_row_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d  = row_count;
          issued_d = '0;
          popped_d = '0;
          if (row_count != '0) begin
            addr_d  = base_address;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d   = next_address(addr_q);
          issued_d = issued_q + 1'b1;
          if (issued_q == count_q - 1'b1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && last_row) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The shift register mirrors the register-file pipe, so it freezes with it.
    if (enable) begin
      sr_valid_d  = {sr_valid_q[READ_LATENCY-2:0], issue};
      sr_row_d[0] = addr_q;
      for (int i = 1; i < READ_LATENCY; i++) sr_row_d[i] = sr_row_q[i-1];
    end

    case ({issue, push})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      addr_q      <= '0;
      in_flight_q <= '0;
      sr_valid_q  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) sr_row_q[i] <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      addr_q      <= addr_d;
      in_flight_q <= in_flight_d;
      sr_valid_q  <= sr_valid_d;
      sr_row_q    <= sr_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign rf_read_address = addr_q;
  assign dbg_state       = state_q;

  drain_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // The credit rule must make a push into a full, non-draining FIFO impossible.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_accumulator_drain.sv
// Directed bench for accumulator_drain with a behavioural register-file read pipe.
module tb_accumulator_drain;
  import accumulator_drain_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, start = 1'b0, out_ready = 1'b1;
  ACCUMULATOR_ADDRESS_TYPE base_address = '0;
  ROW_COUNT_TYPE           row_count = '0;
  logic                    busy, done, out_valid, out_last;
  ACCUMULATOR_ADDRESS_TYPE rf_read_address, out_row;
  ROW_TYPE                 rf_read_port, out_data;
  drain_state_e            dbg_state;

  int checks = 0;
  int failures = 0;
  logic [ADDR_WIDTH-1:0] exp_q[$];
  ACCUMULATOR_ADDRESS_TYPE rf_pipe [READ_LATENCY];

  accumulator_drain dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .base_address(base_address), .row_count(row_count),
    .busy(busy), .done(done), .rf_read_address(rf_read_address),
    .rf_read_port(rf_read_port), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Register file model: 7 enabled stages from address to data, contents derived from address.
  function automatic ROW_TYPE row_of(input ACCUMULATOR_ADDRESS_TYPE a);
    ROW_TYPE r;
    for (int j = 0; j < MATRIX_WIDTH; j++) r[j] = 32'hC0DE_0000 | (WORD_TYPE'(a) << 8) | WORD_TYPE'(j);
    return r;
  endfunction

  initial for (int i = 0; i < READ_LATENCY; i++) rf_pipe[i] = '0;

  always @(posedge clk) begin
    if (enable) begin
      rf_pipe[0] <= rf_read_address;
      for (int i = 1; i < READ_LATENCY; i++) rf_pipe[i] <= rf_pipe[i-1];
    end
  end

  assign rf_read_port = row_of(rf_pipe[READ_LATENCY-1]);

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue_start(input int base, input int count);
    start = 1'b1;
    base_address = ACCUMULATOR_ADDRESS_TYPE'(base);
    row_count = ROW_COUNT_TYPE'(count);
    step();
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %0b expected 0", out_last); end
    checks++; if (rf_read_address !== '0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", rf_read_address); end
    checks++; if (out_row !== '0 || out_data !== '0) begin failures++; $display("FAIL reset_out: got row %0d data %0h expected 0", out_row, out_data); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_release: got busy %0b valid %0b expected 0 0", busy, out_valid); end
  endtask

  task automatic test_basic();
    ACCUMULATOR_ADDRESS_TYPE ea;
    logic ev;
    issue_start(10, 4);
    for (int k = 1; k <= 14; k++) begin
      if (k <= 4) begin
        ea = ACCUMULATOR_ADDRESS_TYPE'(9 + k);
        checks++; if (rf_read_address !== ea) begin failures++; $display("FAIL basic_addr k=%0d: got %0d expected %0d", k, rf_read_address, ea); end
      end
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b expected 1", busy); end
      end
      ev = (k >= 9 && k <= 12);
      checks++; if (out_valid !== ev) begin failures++; $display("FAIL basic_valid k=%0d: got %0b expected %0b", k, out_valid, ev); end
      if (ev) begin
        ea = ACCUMULATOR_ADDRESS_TYPE'(1 + k);
        checks++; if (out_row !== ea || out_data !== row_of(ea)) begin failures++; $display("FAIL basic_row k=%0d: got row %0d data %0h expected row %0d data %0h", k, out_row, out_data, ea, row_of(ea)); end
      end
      checks++; if (out_last !== (k == 12)) begin failures++; $display("FAIL basic_last k=%0d: got %0b expected %0b", k, out_last, k == 12); end
      checks++; if (done !== (k == 13)) begin failures++; $display("FAIL basic_done k=%0d: got %0b expected %0b", k, done, k == 13); end
      step();
    end
  endtask

  task automatic test_wrap();
    ACCUMULATOR_ADDRESS_TYPE ea;
    logic done_seen;
    issue_start(510, 4);
    for (int k = 0; k < 4; k++) begin
      ea = ACCUMULATOR_ADDRESS_TYPE'((510 + k) % REGISTER_DEPTH);
      exp_q.push_back(ea);
      checks++; if (rf_read_address !== ea) begin failures++; $display("FAIL wrap_addr k=%0d: got %0d expected %0d", k, rf_read_address, ea); end
      step();
    end
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (done) done_seen = 1'b1;
      else if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_extra: got row %0d expected none", out_row); end
        else begin
          ea = exp_q.pop_front();
          if (out_row !== ea || out_data !== row_of(ea)) begin failures++; $display("FAIL wrap_row: got row %0d data %0h expected row %0d data %0h", out_row, out_data, ea, row_of(ea)); end
        end
      end
      step();
    end
    checks++; if (!done_seen || exp_q.size() != 0) begin failures++; $display("FAIL wrap_complete: got done %0b left %0d expected done 1 left 0", done_seen, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_pressure();
    ACCUMULATOR_ADDRESS_TYPE ea;
    logic done_seen;
    out_ready = 1'b0;
    issue_start(100, 20);
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        checks++; if (out_row !== 9'd100 || out_data !== row_of(9'd100)) begin failures++; $display("FAIL bp_stable c=%0d: got row %0d expected 100", c, out_row); end
      end
      step();
    end
    checks++; if (rf_read_address !== 9'd108) begin failures++; $display("FAIL bp_issued: got addr %0d expected 108", rf_read_address); end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL bp_hold: got valid %0b busy %0b expected 1 1", out_valid, busy); end
    for (int k = 0; k < 20; k++) exp_q.push_back(ACCUMULATOR_ADDRESS_TYPE'(100 + k));
    out_ready = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 80 && !done_seen; c++) begin
      if (done) done_seen = 1'b1;
      else if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra: got row %0d expected none", out_row); end
        else begin
          ea = exp_q.pop_front();
          if (out_row !== ea || out_data !== row_of(ea)) begin failures++; $display("FAIL bp_row: got row %0d data %0h expected row %0d data %0h", out_row, out_data, ea, row_of(ea)); end
          checks++; if (out_last !== (exp_q.size() == 0)) begin failures++; $display("FAIL bp_last row %0d: got %0b expected %0b", ea, out_last, exp_q.size() == 0); end
        end
      end
      step();
    end
    checks++; if (!done_seen || exp_q.size() != 0) begin failures++; $display("FAIL bp_complete: got done %0b left %0d expected done 1 left 0", done_seen, exp_q.size()); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_after: got valid %0b expected 0", out_valid); end
    exp_q.delete();
  endtask

  task automatic test_zero_count();
    // The previous command ended at row 119, leaving the address register on 120.
    issue_start(200, 0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %0b expected 1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %0b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL zero_valid: got %0b expected 0", out_valid); end
    checks++; if (rf_read_address !== 9'd120) begin failures++; $display("FAIL zero_addr: got %0d expected 120", rf_read_address); end
    step();
    checks++; if (done !== 1'b0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL zero_after: got done %0b state %0d expected 0 0", done, dbg_state); end
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_quiet c=%0d: got valid %0b busy %0b expected 0 0", c, out_valid, busy); end
      step();
    end
  endtask

  task automatic test_enable_stall();
    ACCUMULATOR_ADDRESS_TYPE ea;
    logic ev;
    issue_start(40, 6);
    // enable low in cycles T+3..T+7; a second start in T+4 must be ignored.
    for (int k = 1; k <= 24; k++) begin
      enable = !(k >= 3 && k <= 7);
      if (k == 4) begin
        start = 1'b1; base_address = 9'd300; row_count = 10'd3;
      end else begin
        start = 1'b0;
      end
      if (k <= 11) begin
        ea = (k <= 2) ? ACCUMULATOR_ADDRESS_TYPE'(39 + k) : (k <= 8) ? 9'd42 : ACCUMULATOR_ADDRESS_TYPE'(34 + k);
        checks++; if (rf_read_address !== ea) begin failures++; $display("FAIL stall_addr k=%0d: got %0d expected %0d", k, rf_read_address, ea); end
      end
      ev = (k >= 14 && k <= 19);
      checks++; if (out_valid !== ev) begin failures++; $display("FAIL stall_valid k=%0d: got %0b expected %0b", k, out_valid, ev); end
      if (ev) begin
        ea = ACCUMULATOR_ADDRESS_TYPE'(26 + k);
        checks++; if (out_row !== ea || out_data !== row_of(ea)) begin failures++; $display("FAIL stall_row k=%0d: got row %0d data %0h expected row %0d data %0h", k, out_row, out_data, ea, row_of(ea)); end
      end
      checks++; if (out_last !== (k == 19)) begin failures++; $display("FAIL stall_last k=%0d: got %0b expected %0b", k, out_last, k == 19); end
      checks++; if (done !== (k == 20)) begin failures++; $display("FAIL stall_done k=%0d: got %0b expected %0b", k, done, k == 20); end
      checks++; if (busy !== (k <= 19)) begin failures++; $display("FAIL stall_busy k=%0d: got %0b expected %0b", k, busy, k <= 19); end
      step();
    end
    start = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    ACCUMULATOR_ADDRESS_TYPE ea;
    logic done_seen;
    issue_start(60, 3);
    repeat (4) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before: got %0b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rmid_async: got busy %0b valid %0b expected 0 0", busy, out_valid); end
    checks++; if (rf_read_address !== '0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL rmid_state: got addr %0d state %0d expected 0 0", rf_read_address, dbg_state); end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue_start(0, 2);
    exp_q.push_back(9'd0);
    exp_q.push_back(9'd1);
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (done) done_seen = 1'b1;
      else if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rmid_extra: got row %0d expected none", out_row); end
        else begin
          ea = exp_q.pop_front();
          if (out_row !== ea || out_data !== row_of(ea)) begin failures++; $display("FAIL rmid_row: got row %0d data %0h expected row %0d data %0h", out_row, out_data, ea, row_of(ea)); end
        end
      end
      step();
    end
    checks++; if (!done_seen || exp_q.size() != 0) begin failures++; $display("FAIL rmid_complete: got done %0b left %0d expected done 1 left 0", done_seen, exp_q.size()); end
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_quiet c=%0d: got row %0d valid %0b expected valid 0", c, out_row, out_valid); end
      step();
    end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    repeat (2) step();
    test_wrap();
    repeat (2) step();
    test_back_pressure();
    repeat (2) step();
    test_zero_count();
    test_enable_stall();
    repeat (2) step();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
